// File: rtl/key_debounce_pkg.sv
// Shared state encodings, cycle defaults and helpers for the key debounce pulser.
package key_debounce_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_PRESSED      = 3'd2,
        ST_HELD         = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } state_t;

    // Board timing at 50 MHz: 20 ms debounce, 1 s hold, 200 ms repeat.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_HOLD_CYCLES     = 50000000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 10000000;

    // Short values so simulations finish quickly.
    localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;
    localparam int unsigned SIM_HOLD_CYCLES     = 10;
    localparam int unsigned SIM_REPEAT_CYCLES   = 3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs (keys and switches).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic stage1;

    // Shift the raw input through two flops; reset loads the idle level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stage1 <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/key_debounce_pulser.sv
// Debounces an active-low pushbutton and produces press/release/hold/repeat
// pulses, a clean pressed level and a wrapping press counter.
module key_debounce_pulser
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_n,
    output logic       level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       hold_pulse,
    output logic       repeat_pulse,
    output logic       event_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned CW =
        $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    logic          btn_sync;
    logic          btn_s;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          held_flag;

    // Released key idles high, so the synchroniser resets to 1.
    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_n),
        .q  (btn_sync)
    );

    assign btn_s = ~btn_sync;

    // Debounce / hold / repeat FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            held_flag     <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            event_pulse   <= 1'b0;
            press_count   <= 8'd0;
        end else if (!en) begin
            // Drop to idle silently; the press count is kept.
            state         <= ST_IDLE;
            cnt           <= '0;
            held_flag     <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            event_pulse   <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            event_pulse   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    level <= 1'b0;
                    cnt   <= '0;
                    if (btn_s) state <= ST_PRESS_WAIT;
                end
                ST_PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state       <= ST_PRESSED;
                        cnt         <= '0;
                        level       <= 1'b1;
                        press_pulse <= 1'b1;
                        event_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!btn_s) begin
                        state     <= ST_RELEASE_WAIT;
                        cnt       <= '0;
                        held_flag <= 1'b0;
                    end else if (cnt == HOLD_LAST) begin
                        state      <= ST_HELD;
                        cnt        <= '0;
                        hold_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!btn_s) begin
                        state     <= ST_RELEASE_WAIT;
                        cnt       <= '0;
                        held_flag <= 1'b1;
                    end else if (cnt == REP_LAST) begin
                        cnt          <= '0;
                        repeat_pulse <= 1'b1;
                        event_pulse  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (btn_s) begin
                        // Release bounce: resume where we were, timing restarts.
                        state <= held_flag ? ST_HELD : ST_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state         <= ST_IDLE;
                        cnt           <= '0;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce_pulser.sv
// Self-checking bench for key_debounce_pulser: directed scenarios plus random
// key activity, all compared against a timestamp-based behavioural model.
module tb_key_debounce_pulser;

    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       btn_n = 1'b1;
    logic       level, press_pulse, release_pulse, hold_pulse, repeat_pulse, event_pulse;
    logic [7:0] press_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Model: synchroniser pipe plus accepted level, wait/phase timestamps.
    bit m_sy1 = 1, m_sy2 = 1;
    bit m_level = 0, m_wait = 0, m_held = 0;
    int m_wait_start = 0, m_phase = 0, m_count = 0;
    bit e_press = 0, e_rel = 0, e_hold = 0, e_rep = 0;
    int t_press = 0;

    key_debounce_pulser #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .btn_n        (btn_n),
        .level        (level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .hold_pulse   (hold_pulse),
        .repeat_pulse (repeat_pulse),
        .event_pulse  (event_pulse),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] dut_vec();
        return {level, press_pulse, release_pulse, hold_pulse, repeat_pulse, event_pulse,
                press_count};
    endfunction

    function automatic logic [13:0] exp_vec();
        return {m_level, e_press, e_rel, e_hold, e_rep, e_press | e_rep, 8'(m_count)};
    endfunction

    task automatic model_edge(input bit b, input bit e, input bit r);
        bit s;
        e_press = 0; e_rel = 0; e_hold = 0; e_rep = 0;
        if (!r) begin
            m_sy1 = 1; m_sy2 = 1; m_level = 0; m_wait = 0; m_held = 0; m_count = 0;
            return;
        end
        s = ~m_sy2;
        m_sy2 = m_sy1;
        m_sy1 = b;
        if (!e) begin
            m_level = 0; m_wait = 0; m_held = 0;
            return;
        end
        if (!m_level) begin
            if (!m_wait) begin
                if (s) begin m_wait = 1; m_wait_start = cyc; end
            end else if (!s) begin
                m_wait = 0;
            end else if (cyc - m_wait_start == D) begin
                m_wait = 0; m_level = 1; e_press = 1; m_held = 0; m_phase = cyc;
                m_count = (m_count + 1) % 256;
            end
        end else begin
            if (!m_wait) begin
                if (!s) begin
                    m_wait = 1; m_wait_start = cyc;
                end else if (!m_held) begin
                    if (cyc - m_phase == H) begin e_hold = 1; m_held = 1; m_phase = cyc; end
                end else if ((cyc - m_phase) % R == 0) begin
                    e_rep = 1;
                end
            end else if (s) begin
                m_wait = 0; m_phase = cyc;
            end else if (cyc - m_wait_start == D) begin
                m_wait = 0; m_level = 0; e_rel = 1;
            end
        end
    endtask

    // Drive inputs, take one clock edge, advance the model, settle past the edge.
    task automatic step(input logic b, input logic e, input logic r);
        btn_n = b; en = e; rst = r;
        @(posedge clk);
        cyc++;
        model_edge(b, e, r);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
            total++;
            if (dut_vec() !== 14'd0) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%b want=%b", cyc, dut_vec(), 14'd0);
            end
        end
    endtask

    task automatic test_clean_press();
        int k;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL idle cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
            end
        end
        k = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b1);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL clean_press cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
            end
            total++;
            if (press_pulse !== (cyc == k + D + 2) || event_pulse !== (cyc == k + D + 2)) begin
                bad++;
                $display("FAIL press_latency cyc=%0d got=%b want=%b", cyc, press_pulse,
                         cyc == k + D + 2);
            end
        end
        total++;
        if (level !== 1'b1 || press_count !== 8'd1) begin
            bad++;
            $display("FAIL press_state got=%b/%0d want=1/1", level, press_count);
        end
    endtask

    task automatic test_bounce();
        int k, n;
        bit pat[$];
        for (int i = 0; i < D + 4; i++) pat.push_back(1'b1);
        pat.push_back(0); pat.push_back(0); pat.push_back(0);
        pat.push_back(1); pat.push_back(1);
        foreach (pat[i]) begin
            step(pat[i], 1'b1, 1'b1);
            total++;
            if (dut_vec() !== exp_vec() || press_pulse !== 1'b0) begin
                bad++;
                $display("FAIL bounce cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
            end
        end
        k = cyc + 1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (press_pulse === 1'b1) begin n++; t_press = cyc; end
            total++;
            if (dut_vec() !== exp_vec() || press_pulse !== (cyc == k + D + 2)) begin
                bad++;
                $display("FAIL bounce_press cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
            end
        end
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL bounce_count got=%0d want=1", n);
        end
    endtask

    task automatic test_long_hold();
        logic [7:0] cnt0;
        bit want_rep;
        cnt0 = press_count;
        while (cyc < t_press + 30) begin
            step(1'b0, 1'b1, 1'b1);
            want_rep = (cyc > t_press + H) && ((cyc - t_press - H) % R == 0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL long_hold cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
            end
            total++;
            if (hold_pulse !== (cyc == t_press + H) || repeat_pulse !== want_rep ||
                event_pulse !== want_rep || press_count !== cnt0) begin
                bad++;
                $display("FAIL hold_timing cyc=%0d got=%b%b%b want=%b%b%b", cyc, hold_pulse,
                         repeat_pulse, event_pulse, cyc == t_press + H, want_rep, want_rep);
            end
        end
    endtask

    task automatic test_release_bounce();
        int k;
        bit pat[$];
        for (int i = 0; i < D + 4; i++) pat.push_back(1'b1);
        for (int i = 0; i < 7; i++) pat.push_back(1'b0);
        foreach (pat[i]) begin
            step(pat[i], 1'b1, 1'b1);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rel_setup cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
            end
        end
        pat.delete();
        pat.push_back(1); pat.push_back(1);
        for (int i = 0; i < 5; i++) pat.push_back(1'b0);
        foreach (pat[i]) begin
            step(pat[i], 1'b1, 1'b1);
            total++;
            if (dut_vec() !== exp_vec() || release_pulse !== 1'b0 || level !== 1'b1) begin
                bad++;
                $display("FAIL rel_bounce cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
            end
        end
        k = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b1);
            total++;
            if (dut_vec() !== exp_vec() || release_pulse !== (cyc == k + D + 2)) begin
                bad++;
                $display("FAIL release cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
            end
        end
        total++;
        if (level !== 1'b0) begin
            bad++;
            $display("FAIL release_level got=%b want=0", level);
        end
    endtask

    task automatic test_reset_mid_hold();
        int k;
        for (int i = 0; i < D + H + 6; i++) step(1'b0, 1'b1, 1'b1);
        total++;
        if (dut_vec() !== exp_vec() || level !== 1'b1) begin
            bad++;
            $display("FAIL held_setup got=%b want=%b", dut_vec(), exp_vec());
        end
        step(1'b0, 1'b1, 1'b0);
        total++;
        if (dut_vec() !== 14'd0) begin
            bad++;
            $display("FAIL reset_mid_hold got=%b want=%b", dut_vec(), 14'd0);
        end
        k = cyc + 1;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 1'b1);
            total++;
            if (dut_vec() !== exp_vec() || press_pulse !== (cyc == k + D + 2) ||
                release_pulse !== 1'b0) begin
                bad++;
                $display("FAIL post_reset cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_wrap_enable();
        int n = 0;
        step(1'b1, 1'b1, 1'b0);
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 14; i++) begin
                step(i < 7 ? 1'b0 : 1'b1, 1'b1, 1'b1);
                if (press_pulse === 1'b1) n++;
                total++;
                if (dut_vec() !== exp_vec()) begin
                    bad++;
                    $display("FAIL wrap cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
                end
            end
        end
        total++;
        if (press_count !== 8'd0 || n !== 256) begin
            bad++;
            $display("FAIL wrap_count got=%0d/%0d want=0/256", press_count, n);
        end
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1);
        total++;
        if (level !== 1'b1 || press_count !== 8'd1) begin
            bad++;
            $display("FAIL en_setup got=%b/%0d want=1/1", level, press_count);
        end
        step(1'b0, 1'b0, 1'b1);
        total++;
        if (level !== 1'b0 || release_pulse !== 1'b0 || press_count !== 8'd1) begin
            bad++;
            $display("FAIL en_drop got=%b%b/%0d want=00/1", level, release_pulse, press_count);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL en_return cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
            end
        end
        total++;
        if (press_count !== 8'd2) begin
            bad++;
            $display("FAIL en_repress got=%0d want=2", press_count);
        end
    endtask

    task automatic test_random();
        bit b = 1;
        int run = 0;
        bit e, r;
        for (int i = 0; i < 4000; i++) begin
            if (run == 0) begin
                b = ~b;
                run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
            end
            run--;
            e = ($urandom_range(0, 59) != 0);
            r = ($urandom_range(0, 499) != 0);
            step(b, e, r);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
            end
            total++;
            if ((press_pulse & release_pulse) !== 1'b0 || (hold_pulse & repeat_pulse) !== 1'b0)
            begin
                bad++;
                $display("FAIL exclusive cyc=%0d got=%b%b%b%b want=no overlap", cyc,
                         press_pulse, release_pulse, hold_pulse, repeat_pulse);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_hold();
        test_release_bounce();
        test_reset_mid_hold();
        test_wrap_enable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
